// File: rtl/fetch_pc_gen_if.sv
// Fetch request channel between the PC generator and the fetch unit, plus the
// redirect and freeze controls that steer the PC.
interface fetch_pc_gen_if #(
  parameter int XLEN        = 64,
  parameter int FETCH_BYTES = 16,
  parameter int NUM_REDIR   = 3
);
  localparam int OFF_W = $clog2(FETCH_BYTES);

  logic [NUM_REDIR-1:0]      i_redir_valid;
  logic [NUM_REDIR*XLEN-1:0] i_redir_pc;
  logic                      i_freeze;
  logic                      i_fetch_ready;
  logic                      o_fetch_valid;
  logic [XLEN-1:0]           o_fetch_pc;
  logic [OFF_W-1:0]          o_fetch_offset;
  logic [OFF_W:0]            o_fetch_bytes;
  logic [15:0]               o_redir_cnt;

  // Handshake: a request transfers on an edge where o_fetch_valid and
  // i_fetch_ready are both 1. While valid is high and ready is low, the PC is
  // held stable. Redirects and freeze bypass the handshake entirely.
  modport master (
    input  i_redir_valid, i_redir_pc, i_freeze, i_fetch_ready,
    output o_fetch_valid, o_fetch_pc, o_fetch_offset, o_fetch_bytes, o_redir_cnt
  );

  modport slave (
    output i_redir_valid, i_redir_pc, i_freeze, i_fetch_ready,
    input  o_fetch_valid, o_fetch_pc, o_fetch_offset, o_fetch_bytes, o_redir_cnt
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Next-fetch-PC generator: prioritised redirects, a one-entry pending redirect
// captured during freeze, and block-aligned sequential advance.
module fetch_pc_gen #(
  parameter int              XLEN        = 64,
  parameter int              FETCH_BYTES = 16,
  parameter int              NUM_REDIR   = 3,
  parameter logic [XLEN-1:0] BOOT_PC     = XLEN'(64'h8000_0000)
) (
  input logic             i_clk,
  input logic             i_rstn,
  fetch_pc_gen_if.master  bus
);
  localparam int OFF_W = $clog2(FETCH_BYTES);

  logic            fetch_valid_q, fetch_valid_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [15:0]     redir_cnt_q, redir_cnt_d;

  logic            sel_valid;
  logic [XLEN-1:0] sel_pc;
  logic [XLEN-1:0] seq_pc;

  // Scan from the highest index down so the lowest asserted source wins.
  always_comb begin
    sel_valid = |bus.i_redir_valid;
    sel_pc    = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (bus.i_redir_valid[k]) sel_pc = bus.i_redir_pc[k*XLEN +: XLEN];
    end
    sel_pc[0] = 1'b0;
  end

  assign seq_pc = {fetch_pc_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} + XLEN'(FETCH_BYTES);

  always_comb begin
    fetch_valid_d = fetch_valid_q;
    fetch_pc_d    = fetch_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    redir_cnt_d   = redir_cnt_q;

    if (sel_valid && (redir_cnt_q != 16'hFFFF)) redir_cnt_d = redir_cnt_q + 16'd1;

    if (bus.i_freeze) begin
      // A redirect seen while frozen is remembered and replayed on release.
      fetch_valid_d = 1'b0;
      if (sel_valid) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = sel_pc;
      end
    end else if (sel_valid) begin
      fetch_pc_d    = sel_pc;
      fetch_valid_d = 1'b1;
      pend_valid_d  = 1'b0;
    end else if (pend_valid_q) begin
      fetch_pc_d    = pend_pc_q;
      fetch_valid_d = 1'b1;
      pend_valid_d  = 1'b0;
    end else if (fetch_valid_q && bus.i_fetch_ready) begin
      fetch_pc_d    = seq_pc;
      fetch_valid_d = 1'b1;
    end else begin
      fetch_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= BOOT_PC;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
      redir_cnt_q   <= '0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      redir_cnt_q   <= redir_cnt_d;
    end
  end

  assign bus.o_fetch_valid  = fetch_valid_q;
  assign bus.o_fetch_pc     = fetch_pc_q;
  assign bus.o_fetch_offset = fetch_pc_q[OFF_W-1:0];
  assign bus.o_fetch_bytes  = (OFF_W+1)'(FETCH_BYTES) - {1'b0, fetch_pc_q[OFF_W-1:0]};
  assign bus.o_redir_cnt    = redir_cnt_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vector table, randomized run
// against a behavioural model, and redirect-counter saturation.
module tb_fetch_pc_gen;
  localparam int          XLEN = 32;
  localparam int          FB   = 16;
  localparam int          NR   = 3;
  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  fetch_pc_gen_if #(.XLEN(XLEN), .FETCH_BYTES(FB), .NUM_REDIR(NR)) bus ();

  fetch_pc_gen #(.XLEN(XLEN), .FETCH_BYTES(FB), .NUM_REDIR(NR), .BOOT_PC(BOOT)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // behavioural reference state
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic [15:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic        found;
    logic [31:0] sel;
    found = 1'b0;
    sel   = '0;
    if (!i_rstn) begin
      m_valid = 1'b0;
      m_pc    = BOOT;
      m_pend.delete();
      m_cnt   = '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (!found && bus.i_redir_valid[k]) begin
          found = 1'b1;
          sel   = bus.i_redir_pc[k*XLEN +: XLEN] & ~32'd1;
        end
      end
      if (found && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (bus.i_freeze) begin
        m_valid = 1'b0;
        if (found) m_pend = '{sel};
      end else if (found) begin
        m_pc    = sel;
        m_valid = 1'b1;
        m_pend.delete();
      end else if (m_pend.size() > 0) begin
        m_pc    = m_pend.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && bus.i_fetch_ready) begin
        m_pc = (m_pc / FB) * FB + FB;
      end else begin
        m_valid = 1'b1;
      end
    end
  endtask

  // driver: apply inputs, take one edge, update model, sample 1ns later
  task automatic apply_cycle(input logic rstn, input logic frz, input logic rdy,
                             input logic [2:0] rv, input logic [31:0] p0,
                             input logic [31:0] p1, input logic [31:0] p2);
    i_rstn            = rstn;
    bus.i_freeze      = frz;
    bus.i_fetch_ready = rdy;
    bus.i_redir_valid = rv;
    bus.i_redir_pc    = {p2, p1, p0};
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rstn;
    logic        frz;
    logic        rdy;
    logic [2:0]  rv;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
    logic        ev;
    logic [31:0] epc;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rstn, input logic frz, input logic rdy, input logic [2:0] rv,
                     input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                     input logic ev, input logic [31:0] epc, input logic [15:0] ecnt);
    vec_t v;
    v = '{rstn, frz, rdy, rv, p0, p1, p2, ev, epc, ecnt};
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_off;
    bus.i_freeze      = 1'b0;
    bus.i_fetch_ready = 1'b0;
    bus.i_redir_valid = '0;
    bus.i_redir_pc    = '0;
    m_valid = 1'b0;
    m_pc    = BOOT;
    m_cnt   = '0;

    //  rstn frz rdy rv      p0            p1            p2            valid pc            cnt
    add(0, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        0, 32'h8000_0000, 16'd0);
    add(0, 1, 1, 3'b111, 32'h1234,     32'h0,        32'h0,        0, 32'h8000_0000, 16'd0);
    add(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h8000_0000, 16'd0);
    add(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h8000_0010, 16'd0);
    add(1, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h8000_0010, 16'd0);
    add(1, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h8000_0010, 16'd0);
    add(1, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h8000_0010, 16'd0);
    add(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h8000_0020, 16'd0);
    add(1, 0, 0, 3'b100, 32'h0,        32'h0,        32'h1006,     1, 32'h0000_1006, 16'd1);
    add(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h0000_1010, 16'd1);
    add(1, 0, 1, 3'b001, 32'h1001,     32'h0,        32'h0,        1, 32'h0000_1000, 16'd2);
    add(1, 0, 0, 3'b101, 32'h2000,     32'h0,        32'h3000,     1, 32'h0000_2000, 16'd3);
    add(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        0, 32'h0000_2000, 16'd3);
    add(1, 1, 1, 3'b010, 32'h0,        32'h4002,     32'h0,        0, 32'h0000_2000, 16'd4);
    add(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        0, 32'h0000_2000, 16'd4);
    add(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        0, 32'h0000_2000, 16'd4);
    add(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h0000_4002, 16'd4);
    add(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        0, 32'h0000_4002, 16'd4);
    add(1, 1, 1, 3'b010, 32'h0,        32'h4002,     32'h0,        0, 32'h0000_4002, 16'd5);
    add(0, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        0, 32'h8000_0000, 16'd0);
    add(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        0, 32'h8000_0000, 16'd0);
    add(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h8000_0000, 16'd0);
    add(1, 0, 1, 3'b001, 32'hFFFF_FFF8, 32'h0,       32'h0,        1, 32'hFFFF_FFF8, 16'd1);
    add(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0000, 16'd1);

    for (int i = 0; i < vq.size(); i++) begin
      apply_cycle(vq[i].rstn, vq[i].frz, vq[i].rdy, vq[i].rv, vq[i].p0, vq[i].p1, vq[i].p2);
      exp_off = vq[i].epc % FB;
      check($sformatf("vec%0d_valid", i), 64'(bus.o_fetch_valid), 64'(vq[i].ev));
      check($sformatf("vec%0d_pc", i), 64'(bus.o_fetch_pc), 64'(vq[i].epc));
      check($sformatf("vec%0d_offset", i), 64'(bus.o_fetch_offset), 64'(exp_off));
      check($sformatf("vec%0d_bytes", i), 64'(bus.o_fetch_bytes), 64'(FB - exp_off));
      check($sformatf("vec%0d_cnt", i), 64'(bus.o_redir_cnt), 64'(vq[i].ecnt));
    end

    // randomized run against the reference model
    for (int i = 0; i < 2000; i++) begin
      logic [2:0]  rv;
      logic [31:0] p0, p1, p2;
      rv = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      p0 = $urandom;
      p1 = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      p2 = $urandom;
      apply_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), rv, p0, p1, p2);
      check("rnd_valid", 64'(bus.o_fetch_valid), 64'(m_valid));
      check("rnd_pc", 64'(bus.o_fetch_pc), 64'(m_pc));
      check("rnd_offset", 64'(bus.o_fetch_offset), 64'(m_pc % FB));
      check("rnd_bytes", 64'(bus.o_fetch_bytes), 64'(FB - (m_pc % FB)));
      check("rnd_cnt", 64'(bus.o_redir_cnt), 64'(m_cnt));
    end

    // redirect counter saturation
    apply_cycle(0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("sat_reset_cnt", 64'(bus.o_redir_cnt), 64'h0);
    for (int i = 1; i <= 70000; i++) begin
      apply_cycle(1, (i % 5 == 0), 1, 3'b001, 32'h100 + 32'(i % 64), 32'h0, 32'h0);
      if (i == 65534) check("sat_cnt_fffe", 64'(bus.o_redir_cnt), 64'hFFFE);
      if (i == 65535) check("sat_cnt_ffff", 64'(bus.o_redir_cnt), 64'hFFFF);
      if (i == 65536) check("sat_cnt_hold", 64'(bus.o_redir_cnt), 64'hFFFF);
    end
    check("sat_cnt_end", 64'(bus.o_redir_cnt), 64'hFFFF);
    check("sat_cnt_model", 64'(bus.o_redir_cnt), 64'(m_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 64; PC width in bits.
REQ-002 SHALL have parameter FETCH_BYTES, default 16; fetch block size in bytes, a power of two, at least 4.
REQ-003 SHALL have parameter NUM_REDIR, default 3; number of redirect sources, 1 to 8.
REQ-004 SHALL have parameter BOOT_PC, default 64'h8000_0000; first fetch address after reset.
REQ-005 SHALL have port i_clk, input, 1 bit; the single clock, rising-edge active.
REQ-006 SHALL have port i_rstn, input, 1 bit; reset, synchronous and active-low.
REQ-007 SHALL have port i_redir_valid, input, NUM_REDIR bits; redirect request per source, index 0 highest priority.
REQ-008 SHALL have port i_redir_pc, input, NUM_REDIR*XLEN bits; redirect target per source, source k in bits [k*XLEN +: XLEN].
REQ-009 SHALL have port i_freeze, input, 1 bit; freezes all PC advance.
REQ-010 SHALL have port i_fetch_ready, input, 1 bit; fetch unit accepts the current request.
REQ-011 SHALL have port o_fetch_valid, output, 1 bit; fetch request valid.
REQ-012 SHALL have port o_fetch_pc, output, XLEN bits; fetch request address.
REQ-013 SHALL have port o_fetch_offset, output, log2(FETCH_BYTES) bits; equals o_fetch_pc[log2(FETCH_BYTES)-1:0].
REQ-014 SHALL have port o_fetch_bytes, output, log2(FETCH_BYTES)+1 bits; equals FETCH_BYTES minus o_fetch_offset.
REQ-015 SHALL have port o_redir_cnt, output, 16 bits; saturating count of redirect cycles.

Function
REQ-016 SHALL drive o_fetch_valid and o_fetch_pc from registers only; o_fetch_offset and o_fetch_bytes are combinational from o_fetch_pc.
REQ-017 SHALL select the redirect from the lowest-index asserted i_redir_valid bit; the selected PC has bit 0 forced to 0.
REQ-018 SHALL form the sequential PC as o_fetch_pc with its low log2(FETCH_BYTES) bits cleared, plus FETCH_BYTES, wrapping modulo 2^XLEN.
REQ-019 SHALL keep an internal pending-redirect register holding a valid bit and an XLEN-bit PC.
REQ-020 SHALL apply per-edge updates in this priority when i_rstn=1: freeze > live redirect > pending redirect > handshake advance > hold.
REQ-021 SHALL, on freeze, set o_fetch_valid to 0 and hold o_fetch_pc; if any redirect is valid, it loads the selected redirect into the pending register, overwriting older content.
REQ-022 SHALL, on a live redirect with i_freeze=0, set o_fetch_pc to the selected PC, set o_fetch_valid to 1, and clear the pending register, independent of i_fetch_ready.
REQ-023 SHALL, on a pending redirect with no live redirect and i_freeze=0, set o_fetch_pc to the pending PC, set o_fetch_valid to 1, and clear the pending register.
REQ-024 SHALL, when o_fetch_valid=1 and i_fetch_ready=1 with no higher-priority event, set o_fetch_pc to the sequential PC and keep o_fetch_valid at 1.
REQ-025 SHALL otherwise hold o_fetch_pc and set o_fetch_valid to 1; a request stalled by i_fetch_ready=0 keeps its PC stable.
REQ-026 SHALL increment o_redir_cnt on every edge where any i_redir_valid bit is 1 (frozen or not), saturating at 16'hFFFF.
REQ-027 SHALL leave redirect inputs ignored by i_fetch_ready; a redirect never waits for a handshake.

Reset
REQ-028 SHALL, on any edge with i_rstn=0, set o_fetch_valid to 0, o_fetch_pc to BOOT_PC, the pending register to invalid, and o_redir_cnt to 0, overriding all other inputs, including during freeze.
REQ-029 SHALL, on the first edge with i_rstn=1, apply REQ-020; with no freeze or redirect, o_fetch_valid becomes 1 with o_fetch_pc=BOOT_PC.

Verification (XLEN=32, FETCH_BYTES=16, NUM_REDIR=3, BOOT_PC=0x8000_0000)
REQ-030 Reset release, ready=1 -> pc 0x8000_0000, then 0x8000_0010, then 0x8000_0020, with valid=1 throughout.
REQ-031 ready=0 for 3 cycles at pc 0x8000_0010 -> pc and valid stable; ready=1 -> next pc 0x8000_0020.
REQ-032 Redirect src2=0x1006 -> pc 0x1006, offset 6, bytes 10; next accept -> 0x1010. Redirect 0x1001 -> pc 0x1000.
REQ-033 src0=0x2000 and src2=0x3000 in the same cycle -> pc 0x2000; redir_cnt increments by 1.
REQ-034 freeze 4 cycles with src1=0x4002 in cycle 2 -> valid=0 while frozen, pc held; first cycle after release, pc 0x4002 and valid=1. Repeat with rstn=0 in cycle 3 -> pending is discarded and pc is 0x8000_0000.
REQ-035 Redirect 0xFFFF_FFF8, ready=1 -> next pc 0x0000_0000 (wrap). Drive 70000 redirect cycles -> redir_cnt holds 0xFFFF.
